// File: rtl/sdram_ctrl_pkg.sv
// Shared helpers for the SDRAM controller read path: width ratio, address alignment, lane order.
package sdram_ctrl_pkg;

    localparam int unsigned DEF_WB_DW  = 32;
    localparam int unsigned DEF_MEM_DW = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res = res + 1;
        end
        return res;
    endfunction

    function automatic int unsigned calc_scale(input int unsigned wb_dw, input int unsigned mem_dw);
        return wb_dw / mem_dw;
    endfunction

    function automatic int unsigned calc_adr_lsb(input int unsigned wb_dw);
        return clog2(wb_dw / 8);
    endfunction

    // Big-endian order puts the first beat in the most significant lane.
    function automatic int unsigned lane_idx(input int unsigned beat, input int unsigned scale,
                                             input bit big_endian);
        return big_endian ? (scale - 1 - beat) : beat;
    endfunction

    localparam int unsigned SCALE   = calc_scale(DEF_WB_DW, DEF_MEM_DW);
    localparam int unsigned ADR_LSB = calc_adr_lsb(DEF_WB_DW);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with reset storage, registered full and valid flags, output taken from head entry.
module sync_fifo
    import sdram_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 56,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_en
);

    localparam int unsigned PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q, valid_q;
    logic             do_push, do_pop;

    assign do_push  = wr_en & ~full_q;
    assign do_pop   = rd_en & valid_q;
    assign wr_ready = ~full_q;
    assign rd_valid = valid_q;
    assign rd_data  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Flags are registered from next-state count so s_ready never depends combinationally on rd_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == (PTR_W+1)'(DEPTH));
            valid_q <= (count_d != '0);
        end
    end

endmodule

// File: rtl/mem_rd_upsizer_fifo.sv
// Packs SDRAM read beats into Wishbone-width words tagged with their address and buffers them.
// Define MEM_RD_UPSIZER_OVF_EN to enable the sticky overflow flag on dropped beats.
module mem_rd_upsizer_fifo
    import sdram_ctrl_pkg::*;
#(
    parameter int unsigned WB_DW      = 32,
    parameter int unsigned MEM_DW     = 16,
    parameter int unsigned AW         = 24,
    parameter int unsigned DEPTH      = 4,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     s_adr_i,
    input  logic [MEM_DW-1:0] s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic              s_flush_i,
    output logic [AW-1:0]     m_adr_o,
    output logic [WB_DW-1:0]  m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              ovf_o
);

    localparam int unsigned SCALE_P   = calc_scale(WB_DW, MEM_DW);
    localparam int unsigned ADR_LSB_P = calc_adr_lsb(WB_DW);
    localparam int unsigned CNT_W     = (SCALE_P > 1) ? clog2(SCALE_P) : 1;
    localparam logic [AW-1:0] ADR_MASK = ~((AW'(1) << ADR_LSB_P) - AW'(1));

    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d, cur_cnt;
    logic [WB_DW-1:0]    asm_q, asm_d;
    logic [AW-1:0]       adr_q, adr_d;
    logic                beat_acc, word_push;
    logic [AW+WB_DW-1:0] fifo_rd_data;

    assign beat_acc = s_valid_i & s_ready_o;

    // A flush restarts the word; a beat arriving with it becomes beat 0.
    always_comb begin
        cur_cnt    = s_flush_i ? '0 : beat_cnt_q;
        beat_cnt_d = cur_cnt;
        asm_d      = asm_q;
        adr_d      = adr_q;
        word_push  = 1'b0;
        if (beat_acc) begin
            asm_d[lane_idx(32'(cur_cnt), SCALE_P, BIG_ENDIAN)*MEM_DW +: MEM_DW] = s_data_i;
            if (cur_cnt == '0) begin
                adr_d = s_adr_i & ADR_MASK;
            end
            if (32'(cur_cnt) == SCALE_P - 1) begin
                word_push  = 1'b1;
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = cur_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            asm_q      <= '0;
            adr_q      <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            asm_q      <= asm_d;
            adr_q      <= adr_d;
        end
    end

    sync_fifo #(
        .WIDTH (AW + WB_DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (word_push),
        .wr_data  ({adr_d, asm_d}),
        .wr_ready (s_ready_o),
        .rd_data  (fifo_rd_data),
        .rd_valid (m_valid_o),
        .rd_en    (m_ready_i)
    );

    assign m_adr_o  = fifo_rd_data[AW+WB_DW-1 -: AW];
    assign m_data_o = fifo_rd_data[WB_DW-1:0];

`ifdef MEM_RD_UPSIZER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (s_valid_i && !s_ready_o) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_rd_upsizer_fifo.sv
// Directed bench: big/little-endian 32/16 pair sharing stimulus, plus a 64/8 instance.
module tb_mem_rd_upsizer_fifo;

    logic        clk = 1'b0;
    logic        rst_n, rst_c;
    logic [23:0] s_adr;
    logic [15:0] s_data;
    logic        s_valid, s_flush, m_ready;
    logic        s_ready_a, m_valid_a, ovf_a;
    logic [23:0] m_adr_a;
    logic [31:0] m_data_a;
    logic        s_ready_b, m_valid_b, ovf_b;
    logic [23:0] m_adr_b;
    logic [31:0] m_data_b;
    logic [23:0] c_adr;
    logic [7:0]  c_data;
    logic        c_valid, c_flush, c_ready;
    logic        s_ready_c, m_valid_c, ovf_c;
    logic [23:0] m_adr_c;
    logic [63:0] m_data_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_rd_upsizer_fifo #(
        .WB_DW(32), .MEM_DW(16), .AW(24), .DEPTH(4), .BIG_ENDIAN(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .s_adr_i(s_adr), .s_data_i(s_data), .s_valid_i(s_valid),
        .s_ready_o(s_ready_a), .s_flush_i(s_flush), .m_adr_o(m_adr_a), .m_data_o(m_data_a),
        .m_valid_o(m_valid_a), .m_ready_i(m_ready), .ovf_o(ovf_a)
    );

    mem_rd_upsizer_fifo #(
        .WB_DW(32), .MEM_DW(16), .AW(24), .DEPTH(4), .BIG_ENDIAN(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .s_adr_i(s_adr), .s_data_i(s_data), .s_valid_i(s_valid),
        .s_ready_o(s_ready_b), .s_flush_i(s_flush), .m_adr_o(m_adr_b), .m_data_o(m_data_b),
        .m_valid_o(m_valid_b), .m_ready_i(m_ready), .ovf_o(ovf_b)
    );

    mem_rd_upsizer_fifo #(
        .WB_DW(64), .MEM_DW(8), .AW(24), .DEPTH(4), .BIG_ENDIAN(1'b1)
    ) dut_c (
        .clk(clk), .rst_n(rst_c), .s_adr_i(c_adr), .s_data_i(c_data), .s_valid_i(c_valid),
        .s_ready_o(s_ready_c), .s_flush_i(c_flush), .m_adr_o(m_adr_c), .m_data_o(m_data_c),
        .m_valid_o(m_valid_c), .m_ready_i(c_ready), .ovf_o(ovf_c)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_ab(input logic [23:0] adr, input logic [15:0] data, input logic flush);
        s_adr   = adr;
        s_data  = data;
        s_valid = 1'b1;
        s_flush = flush;
        tick();
        s_valid = 1'b0;
        s_flush = 1'b0;
    endtask

    task automatic pop_ab();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic beat_c(input logic [23:0] adr, input logic [7:0] data);
        c_adr   = adr;
        c_data  = data;
        c_valid = 1'b1;
        tick();
        c_valid = 1'b0;
    endtask

    initial begin
        s_adr = '0; s_data = '0; s_valid = 0; s_flush = 0; m_ready = 0;
        c_adr = '0; c_data = '0; c_valid = 0; c_flush = 0; c_ready = 0;
        rst_n = 0; rst_c = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(m_valid_a), 64'd0);
        check("rst_ready", 64'(s_ready_a), 64'd1);
        check("rst_adr", 64'(m_adr_a), 64'd0);
        check("rst_data", 64'(m_data_a), 64'd0);
        check("rst_ovf", 64'(ovf_a), 64'd0);
        rst_n = 1; rst_c = 1;
        tick();

        // Two-beat word, both lane orders
        beat_ab(24'h000100, 16'hAAAA, 1'b0);
        check("t1_no_early_valid", 64'(m_valid_a), 64'd0);
        beat_ab(24'h000102, 16'hBBBB, 1'b0);
        check("t1_valid", 64'(m_valid_a), 64'd1);
        check("t1_data_be", 64'(m_data_a), 64'hAAAABBBB);
        check("t1_adr", 64'(m_adr_a), 64'h100);
        check("t2_data_le", 64'(m_data_b), 64'hBBBBAAAA);
        check("t2_adr_le", 64'(m_adr_b), 64'h100);
        pop_ab();
        check("t1_popped", 64'(m_valid_a), 64'd0);

        // Fill the FIFO with m_ready low; surplus beats are dropped
        for (int i = 0; i < 11; i++) begin
            beat_ab(24'h000200 + 24'(2 * i), 16'h1000 + 16'(i), 1'b0);
            if (i == 6) check("t3_ready_before_full", 64'(s_ready_a), 64'd1);
            if (i == 7) check("t3_full_after_8", 64'(s_ready_a), 64'd0);
        end
        tick();
        check("t3_hold_data", 64'(m_data_a), 64'h10001001);
        for (int w = 0; w < 4; w++) begin
            check("t3_valid", 64'(m_valid_a), 64'd1);
            check("t3_data_be", 64'(m_data_a), {32'd0, 16'h1000 + 16'(2 * w), 16'h1001 + 16'(2 * w)});
            check("t3_data_le", 64'(m_data_b), {32'd0, 16'h1001 + 16'(2 * w), 16'h1000 + 16'(2 * w)});
            check("t3_adr", 64'(m_adr_a), 64'h200 + 64'(4 * w));
            pop_ab();
            check("t3_ready_after_pop", 64'(s_ready_a), 64'd1);
        end
        check("t3_empty", 64'(m_valid_a), 64'd0);
`ifdef MEM_RD_UPSIZER_OVF_EN
        check("t5_ovf_sticky", 64'(ovf_a), 64'd1);
`else
        check("t5_ovf_tied", 64'(ovf_a), 64'd0);
`endif
        // Dropped beats must not have moved the beat counter
        beat_ab(24'h000210, 16'hE001, 1'b0);
        check("t3_cnt_half", 64'(m_valid_a), 64'd0);
        beat_ab(24'h000212, 16'hE002, 1'b0);
        check("t3_cnt_word", 64'(m_data_a), 64'hE001E002);
        check("t3_cnt_adr", 64'(m_adr_a), 64'h210);
        pop_ab();

        rst_n = 0;
        #2;
        check("t5_ovf_reset", 64'(ovf_a), 64'd0);
        check("t5_rst_ready", 64'(s_ready_a), 64'd1);
        rst_n = 1;
        tick();

        // Flush on its own, then a full word with an unaligned first address
        beat_ab(24'h000300, 16'h1234, 1'b0);
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
        beat_ab(24'h000302, 16'h5678, 1'b0);
        check("t4_no_word", 64'(m_valid_a), 64'd0);
        beat_ab(24'h000306, 16'h9ABC, 1'b0);
        check("t4_valid", 64'(m_valid_a), 64'd1);
        check("t4_data", 64'(m_data_a), 64'h56789ABC);
        check("t4_adr", 64'(m_adr_a), 64'h300);
        pop_ab();

        // Flush together with a beat: that beat starts the new word
        beat_ab(24'h000400, 16'h1111, 1'b0);
        beat_ab(24'h000408, 16'h2222, 1'b1);
        check("t4b_no_word", 64'(m_valid_a), 64'd0);
        beat_ab(24'h00040A, 16'h3333, 1'b0);
        check("t4b_data", 64'(m_data_a), 64'h22223333);
        check("t4b_adr", 64'(m_adr_a), 64'h408);
        pop_ab();
        check("t4b_empty", 64'(m_valid_a), 64'd0);

        // 64/8 ratio, address low three bits forced to zero
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) check("t6_no_early_valid", 64'(m_valid_c), 64'd0);
            beat_c(24'h000803 + 24'(i - 1), 8'(i));
        end
        check("t6_valid", 64'(m_valid_c), 64'd1);
        check("t6_data", m_data_c, 64'h0102030405060708);
        check("t6_adr", 64'(m_adr_c), 64'h800);
        c_ready = 1'b1;
        tick();
        c_ready = 1'b0;

        for (int i = 1; i <= 3; i++) beat_c(24'h000900, 8'(i));
        rst_c = 0;
        #2;
        check("t6_rst_valid", 64'(m_valid_c), 64'd0);
        check("t6_rst_data", m_data_c, 64'd0);
        rst_c = 1;
        tick();
        for (int i = 4; i <= 8; i++) beat_c(24'h000A00 + 24'(i), 8'(i));
        check("t6_partial_dropped", 64'(m_valid_c), 64'd0);
        for (int i = 9; i <= 11; i++) beat_c(24'h000B00, 8'(i));
        check("t6_restart_valid", 64'(m_valid_c), 64'd1);
        check("t6_restart_data", m_data_c, 64'h0405060708090A0B);
        check("t6_restart_adr", 64'(m_adr_c), 64'hA00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
